audio_stream_router: RTL and testbench

AUDIO_STREAM_ROUTER -- requirements
Module: audio_stream_router

---
 rtl/audio_stream_router.sv | 195 +++++++++++++++++++
 tb/tb_audio_stream_router.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_router.sv
// Audio stream router: routes one of NUM_SRC multichannel PCM sources to a
// single output frame, with a linear gain ramp on start-up and on every
// source change so that switches are click-free.
module audio_stream_router #(
    parameter  int NUM_SRC    = 4,
    parameter  int NUM_CH     = 2,
    parameter  int DATA_W     = 24,
    parameter  int RAMP_SHIFT = 6,
    localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             run,
    input  logic [SEL_W-1:0]                 select,
    input  logic [NUM_SRC*NUM_CH-1:0]        src_valid,
    input  logic [NUM_SRC*NUM_CH*DATA_W-1:0] src_data,
    output logic                             out_valid,
    output logic [NUM_CH*DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]                 active_sel,
    output logic [2:0]                       state,
    output logic                             overrun
);

    localparam int                GAIN_W   = RAMP_SHIFT + 1;
    localparam int                PROD_W   = DATA_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] GAIN_MAX = {1'b1, {RAMP_SHIFT{1'b0}}};
    localparam logic [SEL_W:0]    SRC_LIM  = (SEL_W + 1)'(NUM_SRC);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        PASS      = 3'd2,
        RAMP_DOWN = 3'd3,
        SWITCH    = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [GAIN_W-1:0]           gain_q, gain_d;
    logic [NUM_CH-1:0]           pend_q, pend_d;
    logic signed [DATA_W-1:0]    hold_q [NUM_CH];
    logic signed [DATA_W-1:0]    hold_d [NUM_CH];
    logic [SEL_W-1:0]            active_sel_q, active_sel_d;
    logic                        overrun_q, overrun_d;
    logic                        out_valid_q, out_valid_d;
    logic [NUM_CH*DATA_W-1:0]    out_data_q, out_data_d;

    logic [NUM_CH-1:0]           strb;
    logic [NUM_CH*DATA_W-1:0]    smp;
    logic                        sel_ok;
    logic                        sel_diff;
    logic                        frame_full;

    // Signed sample times unsigned gain, then floor division by RAMP_LEN.
    // Gain never exceeds RAMP_LEN, so the result always fits DATA_W bits.
    function automatic logic signed [DATA_W-1:0] scale(
        input logic signed [DATA_W-1:0] s,
        input logic [GAIN_W-1:0]        g
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(s) * PROD_W'($signed({1'b0, g}));
        return DATA_W'(prod >>> RAMP_SHIFT);
    endfunction

    assign sel_ok     = {1'b0, select} < SRC_LIM;
    assign sel_diff   = sel_ok && (select != active_sel_q);
    assign frame_full = &pend_q;

    // Pick out the strobes and samples belonging to the routed source.
    always_comb begin
        strb = '0;
        smp  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (active_sel_q == SEL_W'(s)) begin
                strb = src_valid[s*NUM_CH +: NUM_CH];
                smp  = src_data[s*NUM_CH*DATA_W +: NUM_CH*DATA_W];
            end
        end
    end

    // Next-state logic: capture, frame emission, gain ramp and mode sequencing.
    always_comb begin
        state_d      = state_q;
        gain_d       = gain_q;
        pend_d       = pend_q;
        hold_d       = hold_q;
        active_sel_d = active_sel_q;
        overrun_d    = overrun_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;

        if (state_q == IDLE) begin
            overrun_d = 1'b0;
            if (sel_ok) begin
                active_sel_d = select;
            end
        end

        if (!run || state_q == IDLE) begin
            // Stopped (or starting): discard any partial frame, mute output.
            state_d    = run ? RAMP_UP : IDLE;
            gain_d     = '0;
            pend_d     = '0;
            out_data_d = '0;
        end else if (state_q == SWITCH) begin
            if (sel_ok) begin
                active_sel_d = select;
            end
            pend_d  = '0;
            state_d = RAMP_UP;
        end else begin
            if (frame_full) begin
                out_valid_d = 1'b1;
                pend_d      = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    out_data_d[c*DATA_W +: DATA_W] = scale(hold_q[c], gain_q);
                end
            end

            // A strobe landing on the emit edge starts the next frame.
            for (int c = 0; c < NUM_CH; c++) begin
                if (strb[c]) begin
                    if (pend_q[c] && !frame_full) begin
                        overrun_d = 1'b1;
                    end
                    hold_d[c] = smp[c*DATA_W +: DATA_W];
                    pend_d[c] = 1'b1;
                end
            end

            case (state_q)
                RAMP_UP: begin
                    if (sel_diff) begin
                        state_d = RAMP_DOWN;
                    end else if (gain_q == GAIN_MAX) begin
                        state_d = PASS;
                    end else if (frame_full) begin
                        gain_d = gain_q + 1'b1;
                        if ((gain_q + 1'b1) == GAIN_MAX) begin
                            state_d = PASS;
                        end
                    end
                end
                PASS: begin
                    if (sel_diff) begin
                        state_d = RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (select == active_sel_q) begin
                        state_d = RAMP_UP;
                    end else if (gain_q == '0) begin
                        state_d = SWITCH;
                    end else if (frame_full) begin
                        gain_d = gain_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gain_q       <= '0;
            pend_q       <= '0;
            active_sel_q <= '0;
            overrun_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                hold_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            pend_q       <= pend_d;
            active_sel_q <= active_sel_d;
            overrun_q    <= overrun_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            hold_q       <= hold_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign active_sel = active_sel_q;
    assign state      = state_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_stream_router.sv
// Testbench for audio_stream_router: directed scenarios followed by random
// traffic, every cycle compared against a frame-level reference model.
module tb_audio_stream_router;

    localparam int NUM_SRC    = 4;
    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 24;
    localparam int RAMP_SHIFT = 2;
    localparam int RAMP_LEN   = 4;

    logic         clk;
    logic         reset_n;
    logic         run;
    logic [1:0]   select;
    logic [7:0]   src_valid;
    logic [191:0] src_data;
    logic         out_valid;
    logic [47:0]  out_data;
    logic [1:0]   active_sel;
    logic [2:0]   dut_state;
    logic         overrun;

    int vectors;
    int miscompares;

    // Reference model state (mode codes: 0 idle, 1 up, 2 pass, 3 down, 4 switch)
    int          m_mode;
    int          m_gain;
    int          m_sel;
    logic [1:0]  m_pend;
    int          m_hold [2];
    logic        m_ovr;
    logic        m_ov;
    logic [47:0] m_od;

    audio_stream_router #(
        .NUM_SRC   (NUM_SRC),
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .RAMP_SHIFT(RAMP_SHIFT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .select    (select),
        .src_valid (src_valid),
        .src_data  (src_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .active_sel(active_sel),
        .state     (dut_state),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic int floor_scale(int h, int g);
        int p;
        p = h * g;
        if (p >= 0) return p / RAMP_LEN;
        return -((-p + RAMP_LEN - 1) / RAMP_LEN);
    endfunction

    function automatic int sx24(logic [23:0] d);
        return int'(signed'(d));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_gain = 0; m_sel = 0; m_pend = 2'b00;
        m_hold[0] = 0; m_hold[1] = 0;
        m_ovr = 1'b0; m_ov = 1'b0; m_od = '0;
    endtask

    // One clock edge of the reference, computed from the pre-edge model state.
    task automatic model_step();
        int          nmode, ngain, nsel;
        logic [1:0]  npend;
        int          nhold [2];
        logic        novr, nov, full, sel_ok;
        logic [47:0] nod;
        nmode = m_mode; ngain = m_gain; nsel = m_sel; npend = m_pend;
        nhold = m_hold; novr = m_ovr; nov = 1'b0; nod = m_od;
        full   = (m_pend == 2'b11);
        sel_ok = (int'(select) < NUM_SRC);
        if (m_mode == 0) begin
            novr = 1'b0;
            if (sel_ok) nsel = int'(select);
        end
        if (!run || m_mode == 0) begin
            nmode = run ? 1 : 0; ngain = 0; npend = 2'b00; nod = '0;
        end else if (m_mode == 4) begin
            if (sel_ok) nsel = int'(select);
            npend = 2'b00; nmode = 1;
        end else begin
            if (full) begin
                nov = 1'b1;
                npend = 2'b00;
                for (int c = 0; c < 2; c++)
                    nod[c*24 +: 24] = 24'(floor_scale(m_hold[c], m_gain));
            end
            for (int c = 0; c < 2; c++) begin
                if (src_valid[m_sel*2 + c]) begin
                    if (m_pend[c] && !full) novr = 1'b1;
                    nhold[c] = sx24(src_data[(m_sel*2 + c)*24 +: 24]);
                    npend[c] = 1'b1;
                end
            end
            if (m_mode == 1) begin
                if (sel_ok && int'(select) != m_sel) nmode = 3;
                else if (m_gain == RAMP_LEN) nmode = 2;
                else if (full) begin
                    ngain = m_gain + 1;
                    if (ngain == RAMP_LEN) nmode = 2;
                end
            end else if (m_mode == 2) begin
                if (sel_ok && int'(select) != m_sel) nmode = 3;
            end else begin
                if (int'(select) == m_sel) nmode = 1;
                else if (m_gain == 0) nmode = 4;
                else if (full) ngain = m_gain - 1;
            end
        end
        m_mode = nmode; m_gain = ngain; m_sel = nsel; m_pend = npend;
        m_hold = nhold; m_ovr = novr; m_ov = nov; m_od = nod;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m_out_valid",  64'(out_valid),  64'(m_ov));
        chk("m_out_data",   64'(out_data),   64'(m_od));
        chk("m_state",      64'(dut_state),  64'(m_mode));
        chk("m_active_sel", 64'(active_sel), 64'(m_sel));
        chk("m_overrun",    64'(overrun),    64'(m_ovr));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        check_model();
    endtask

    task automatic drive(int s, int c, logic [23:0] d);
        src_valid[s*2 + c] = 1'b1;
        src_data[(s*2 + c)*24 +: 24] = d;
    endtask

    task automatic frame(int s, logic [23:0] l, logic [23:0] r);
        drive(s, 0, l);
        drive(s, 1, r);
        cycle();
        src_valid = '0;
        cycle();
    endtask

    initial begin
        logic [23:0] up_l [5];
        logic [23:0] up_r [5];
        logic [23:0] dn_l [4];
        vectors = 0; miscompares = 0;
        up_l = '{24'h000000, 24'h040000, 24'h080000, 24'h0C0000, 24'h100000};
        up_r = '{24'h000000, 24'hFC0000, 24'hF80000, 24'hF40000, 24'hF00000};
        dn_l = '{24'h100000, 24'h0C0000, 24'h080000, 24'h040000};
        reset_n = 1'b0; run = 1'b0; select = 2'd0; src_valid = '0; src_data = '0;
        model_reset();

        // Power-on reset
        cycle(); cycle();
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_data",   64'(out_data),   64'd0);
        chk("rst_state",      64'(dut_state),  64'd0);
        chk("rst_active_sel", 64'(active_sel), 64'd0);
        chk("rst_overrun",    64'(overrun),    64'd0);
        reset_n = 1'b1;
        cycle();

        // Ramp-up on source 1
        run = 1'b1; select = 2'd1;
        cycle();
        chk("up_state", 64'(dut_state), 64'd1);
        chk("up_sel",   64'(active_sel), 64'd1);
        for (int k = 0; k < 5; k++) begin
            frame(1, 24'h100000, 24'hF00000);
            chk("up_valid", 64'(out_valid), 64'd1);
            chk("up_L", 64'(out_data[23:0]),  64'(up_l[k]));
            chk("up_R", 64'(out_data[47:24]), 64'(up_r[k]));
        end
        chk("up_pass", 64'(dut_state), 64'd2);

        // Overrun: left channel strobed twice before right
        drive(1, 0, 24'h000111); cycle(); src_valid = '0;
        drive(1, 0, 24'h000222); cycle(); src_valid = '0;
        chk("ovr_set", 64'(overrun), 64'd1);
        drive(1, 1, 24'h000333); cycle(); src_valid = '0;
        cycle();
        chk("ovr_valid", 64'(out_valid), 64'd1);
        chk("ovr_L", 64'(out_data[23:0]),  64'h000222);
        chk("ovr_R", 64'(out_data[47:24]), 64'h000333);

        // Source change 1 -> 2
        select = 2'd2;
        cycle();
        chk("dn_state", 64'(dut_state), 64'd3);
        for (int k = 0; k < 4; k++) begin
            frame(1, 24'h100000, 24'hF00000);
            chk("dn_L", 64'(out_data[23:0]), 64'(dn_l[k]));
        end
        cycle();
        chk("sw_state", 64'(dut_state), 64'd4);
        cycle();
        chk("sw_after_state", 64'(dut_state), 64'd1);
        chk("sw_after_sel",   64'(active_sel), 64'd2);
        frame(2, 24'h200000, 24'h200000);
        chk("src2_g0", 64'(out_data[23:0]), 64'h000000);
        frame(2, 24'h200000, 24'h200000);
        chk("src2_g1", 64'(out_data[23:0]), 64'h080000);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        run = 1'b0;
        cycle();
        chk("stop_state", 64'(dut_state), 64'd0);
        cycle();
        chk("ovr_clear", 64'(overrun), 64'd0);

        // Strobes on a non-routed source are ignored
        select = 2'd1; run = 1'b1;
        cycle();
        for (int k = 0; k < 6; k++) begin
            drive(3, 0, 24'($urandom)); drive(3, 1, 24'($urandom));
            cycle();
            chk("foreign_novalid", 64'(out_valid), 64'd0);
        end
        src_valid = '0;
        drive(1, 0, 24'h123456); drive(1, 1, 24'h654321);
        cycle();
        chk("same_edge_wait", 64'(out_valid), 64'd0);
        src_valid = '0;
        cycle();
        chk("same_edge_valid", 64'(out_valid), 64'd1);

        // Floor shift of a negative sample, then stop during ramp-up
        frame(1, 24'hFFFFFF, 24'hFFFFFF);
        chk("floor_L", 64'(out_data[23:0]),  64'hFFFFFF);
        chk("floor_R", 64'(out_data[47:24]), 64'hFFFFFF);
        run = 1'b0;
        cycle();
        chk("drop_state", 64'(dut_state), 64'd0);
        chk("drop_data",  64'(out_data),  64'd0);

        // Asynchronous reset in the middle of a stream
        run = 1'b1;
        cycle();
        frame(1, 24'h100000, 24'h100000);
        frame(1, 24'h100000, 24'h100000);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 64'(out_valid),  64'd0);
        chk("arst_data",  64'(out_data),   64'd0);
        chk("arst_state", 64'(dut_state),  64'd0);
        chk("arst_sel",   64'(active_sel), 64'd0);
        chk("arst_ovr",   64'(overrun),    64'd0);
        cycle();
        reset_n = 1'b1;
        cycle();
        frame(1, 24'h100000, 24'h100000);
        chk("arst_first_valid", 64'(out_valid), 64'd1);
        chk("arst_first_data",  64'(out_data),  64'd0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            run = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 39) == 0) select = 2'($urandom_range(0, 3));
            for (int b = 0; b < 8; b++) src_valid[b] = ($urandom_range(0, 2) == 0);
            src_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (i == 1000) reset_n = 1'b0;
            if (i == 1002) reset_n = 1'b1;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
